// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch squash and data-memory wait with timeout.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2,
  parameter int MEM_TIMEOUT    = 256
`ifdef HAZARD_PERF_EN
  ,parameter int CNT_WIDTH     = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic                      ex_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
  input  logic                      ex_branch_taken,
  input  logic                      dmem_busy,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_stall,
  output logic                      id_ex_flush,
  output logic                      ex_mem_stall,
  output logic                      mem_timeout
`ifdef HAZARD_PERF_EN
  ,output logic [CNT_WIDTH-1:0]     stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_events
`endif
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [FW-1:0] FCNT_INIT = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0] TCNT_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;

  logic load_use;
  logic resolve_run;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c;
  logic ex_mem_stall_c, mem_timeout_c;

  assign load_use = ex_mem_rd_en && (ex_reg_wr_addr != '0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_reg_wr_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_reg_wr_addr)));

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    tcnt_d         = tcnt_q;
    resolve_run    = 1'b0;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    mem_timeout_c  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_busy) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_stall_c = 1'b1;
          state_d        = ST_MEM_WAIT;
          tcnt_d         = TCNT_ONE;
        end else begin
          resolve_run = 1'b1;
        end
      end
      ST_FLUSH: begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        if (dmem_busy) begin
          pc_stall_c     = 1'b1;
          ex_mem_stall_c = 1'b1;
        end else begin
          fcnt_d = fcnt_q - FCNT_ONE;
          if (fcnt_q == FCNT_ONE) state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_busy) begin
          if (tcnt_q == TCNT_LAST) begin
            mem_timeout_c = 1'b1;
            state_d       = ST_RUN;
            tcnt_d        = '0;
          end else begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
            tcnt_d         = tcnt_q + TCNT_ONE;
          end
        end else begin
          // Release cycle behaves as RUN so a branch or load held in EX during the wait is still honoured.
          state_d     = ST_RUN;
          tcnt_d      = '0;
          resolve_run = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = '0;
        tcnt_d  = '0;
      end
    endcase

    if (resolve_run) begin
      if (ex_branch_taken) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_INIT;
        end
      end else if (load_use) begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Outputs are gated by rst_n so they drop the instant reset asserts.
  assign pc_stall     = rst_n & pc_stall_c;
  assign if_id_stall  = rst_n & if_id_stall_c;
  assign if_id_flush  = rst_n & if_id_flush_c;
  assign id_ex_stall  = rst_n & id_ex_stall_c;
  assign id_ex_flush  = rst_n & id_ex_flush_c;
  assign ex_mem_stall = rst_n & ex_mem_stall_c;
  assign mem_timeout  = rst_n & mem_timeout_c;

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] flush_events_q, flush_events_d;
  logic                 flush_accept;

  assign flush_accept = (state_q == ST_RUN) && !dmem_busy && ex_branch_taken;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    if (flush_accept && (flush_events_q != '1)) flush_events_d = flush_events_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
